// File: rtl/button_pkg.sv
// Shared types for the button conditioning path.
// Contents:
//   btn_state_t         - per-channel debounce FSM states
//   btn_released_level  - raw pad level of a released button for a given polarity
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // A low-active button idles high on the pad; a high-active one idles low.
  function automatic logic btn_released_level(input bit low_active);
    return low_active ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM with stability counter,
// press-edge pulse and (with BTN_FRAME_LATCH_EN) a press latch held until the
// next frame strobe.
// Ports:
//   CLK, RST_N  - pixel clock, async active-low reset
//   raw         - asynchronous pad level (polarity given by LOW_ACTIVE)
//   frame_tick  - one-cycle frame strobe (used only with BTN_FRAME_LATCH_EN)
//   level       - debounced pressed state, active-high
//   press       - one-cycle pulse when a press is accepted
//   frame       - level, or level | latch when BTN_FRAME_LATCH_EN is defined
module debounce_channel
  import button_pkg::*;
#(
  parameter bit          LOW_ACTIVE      = 1'b1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw,
  input  logic frame_tick,
  output logic level,
  output logic press,
  output logic frame
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic             REL     = btn_released_level(LOW_ACTIVE);
  localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{REL}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  btn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_d, press_d;

  // The pad is synchronised untouched so nothing sits in front of the first
  // flop; polarity is resolved on the synchronised bit.
  assign synced = sync_q[SYNC_STAGES-1] ^ LOW_ACTIVE;

  // State, counter, synchroniser and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q  <= SYNC_RST;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      press   <= press_d;
    end
  end

  // Next state: a wait state needs DEBOUNCE_CYCLES+1 agreeing samples
  // (entry sample plus DEBOUNCE_CYCLES more); any disagreeing sample aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (synced) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

`ifdef BTN_FRAME_LATCH_EN
  logic latch_q, latch_d;

  // Set by the press pulse, cleared by the frame strobe; set wins.
  always_comb begin
    latch_d = press | (latch_q & ~frame_tick);
  end

  // frame is registered from the same next values that load level and latch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      latch_q <= 1'b0;
      frame   <= 1'b0;
    end else begin
      latch_q <= latch_d;
      frame   <= level_d | latch_d;
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign frame             = level;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the player push-buttons feeding the
// pong pixel engine. Outputs are active-high.
// Optional feature macro: BTN_FRAME_LATCH_EN (hold each press until frame_tick).
// Ports:
//   CLK, RST_N  - pixel clock, async active-low reset
//   btns_raw    - pads: [3] p1 up, [2] p1 down, [1] p2 up, [0] p2 down
//   frame_tick  - one-cycle NEXT_FRAME strobe
//   btns_level  - debounced pressed state
//   btns_press  - one-cycle pulse per accepted press
//   btns_frame  - per-frame button state for the engine
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BTNS          = 4,
  parameter int unsigned BUTTON_LOW_ACTIVE = 1,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 250000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_BTNS-1:0] btns_raw,
  input  logic                frame_tick,
  output logic [NUM_BTNS-1:0] btns_level,
  output logic [NUM_BTNS-1:0] btns_press,
  output logic [NUM_BTNS-1:0] btns_frame
);

  // Any non-zero setting selects low-active pads.
  localparam bit LOW_ACTIVE = (BUTTON_LOW_ACTIVE != 0);

  for (genvar i = 0; i < int'(NUM_BTNS); i++) begin : g_btn
    debounce_channel #(
      .LOW_ACTIVE      (LOW_ACTIVE),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .raw        (btns_raw[i]),
      .frame_tick (frame_tick),
      .level      (btns_level[i]),
      .press      (btns_press[i]),
      .frame      (btns_frame[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model feeding a
// per-cycle expectation queue, an independent monitor, directed scenarios
// from the test plan and a randomized phase.
module tb_button_conditioner;

  localparam int unsigned N    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b1;
  logic [N-1:0] btns_raw   = '1;
  logic         frame_tick = 1'b0;
  logic [N-1:0] btns_level, btns_press, btns_frame;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] frame;
  } exp_t;

  exp_t q[$];
  bit   started = 1'b0;

  // Reference state: history of active-high samples, accepted level,
  // length of the current run of samples disagreeing with it, last pulse, latch.
  bit hist [N][SYNC];
  bit m_level [N];
  int m_run [N];
  bit m_press [N];
  bit m_latch [N];

  button_conditioner #(
    .NUM_BTNS          (N),
    .BUTTON_LOW_ACTIVE (1),
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DEB)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .btns_raw   (btns_raw),
    .frame_tick (frame_tick),
    .btns_level (btns_level),
    .btns_press (btns_press),
    .btns_frame (btns_frame)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int b = 0; b < int'(N); b++) begin
      for (int s = 0; s < int'(SYNC); s++) hist[b][s] = 1'b0;
      m_level[b] = 1'b0;
      m_run[b]   = 0;
      m_press[b] = 1'b0;
      m_latch[b] = 1'b0;
    end
  endtask

  // A level change is accepted once DEB+1 consecutive synchronised samples
  // disagree with the current level; the sample seen at an edge is the pad
  // value from SYNC edges earlier.
  task automatic model_step();
    exp_t e;
    bit   synced;
    e = '0;
    for (int b = 0; b < int'(N); b++) begin
      synced = hist[b][SYNC-1];
      for (int s = int'(SYNC) - 1; s > 0; s--) hist[b][s] = hist[b][s-1];
      hist[b][0] = ~btns_raw[b];
      m_latch[b] = m_press[b] | (m_latch[b] & ~frame_tick);
      m_press[b] = 1'b0;
      if (synced != m_level[b]) m_run[b] = m_run[b] + 1;
      else m_run[b] = 0;
      if (m_run[b] == int'(DEB) + 1) begin
        m_level[b] = synced;
        m_run[b]   = 0;
        m_press[b] = synced;
      end
      e.level[b] = m_level[b];
      e.press[b] = m_press[b];
`ifdef BTN_FRAME_LATCH_EN
      e.frame[b] = m_level[b] | m_latch[b];
`else
      e.frame[b] = m_level[b];
`endif
    end
    q.push_back(e);
  endtask

  // Model clocked alongside the DUT; pushes the expectation for this cycle.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst_n) begin
        model_reset();
        q.push_back('0);
      end else begin
        model_step();
      end
    end
  end

  // Asynchronous reset replaces the expectation of the current cycle.
  initial begin
    forever begin
      @(negedge rst_n);
      model_reset();
      if (q.size() > 0) q[q.size()-1] = '0;
    end
  end

  // Monitor: one expectation per cycle, sampled on the falling edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (q.size() == 0) begin
        if (started) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow t=%0t", $time);
        end
      end else begin
        e = q.pop_front();
        tests++;
        if ({btns_level, btns_press, btns_frame} !== e) begin
          fails++;
          $display("FAIL cycle_check t=%0t level=%h exp %h press=%h exp %h frame=%h exp %h",
                   $time, btns_level, e.level, btns_press, e.press, btns_frame, e.frame);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int npress;
    int rise;
    int pat [7];
    int hold [N];

    pat = '{0, 0, 1, 0, 0, 0, 1};

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_level", 32'(btns_level), 32'h0);
    repeat (3) step();
    check("reset_level", 32'(btns_level), 32'h0);
    check("reset_press", 32'(btns_press), 32'h0);
    check("reset_frame", 32'(btns_frame), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_reset_level", 32'(btns_level), 32'h0);
    repeat (5) step();

    // 1. Clean press of bit 3
    btns_raw = 4'h7;
    repeat (6) step();
    check("t1_level_before_edge6", 32'(btns_level), 32'h0);
    step();
    check("t1_level_edge6", 32'(btns_level), 32'h8);
    check("t1_press_edge6", 32'(btns_press), 32'h8);
    step();
    check("t1_press_single", 32'(btns_press), 32'h0);
    check("t1_level_held", 32'(btns_level), 32'h8);
    repeat (3) step();

    // 3. Release of bit 3
    btns_raw = 4'hF;
    npress = 0;
    repeat (6) begin
      step();
      npress += int'(btns_press[3]);
    end
    check("t3_level_before_edge6", 32'(btns_level), 32'h8);
    step();
    npress += int'(btns_press[3]);
    check("t3_level_edge6", 32'(btns_level), 32'h0);
    check("t3_no_press", 32'(npress), 32'h0);
    repeat (3) step();

    // 2. Bounce on bit 3
    npress = 0;
    for (int i = 0; i < 7; i++) begin
      btns_raw[3] = pat[i][0];
      step();
      npress += int'(btns_press[3]);
    end
    btns_raw[3] = 1'b0;
    rise = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      npress += int'(btns_press[3]);
      if (btns_level[3] && rise < 0) rise = k;
    end
    check("t2_rise_edge", 32'(rise), 32'd6);
    check("t2_press_count", 32'(npress), 32'd1);
    btns_raw = 4'hF;
    repeat (10) step();

`ifdef BTN_FRAME_LATCH_EN
    // 4. Short tap held until the next frame strobe
    btns_raw[3] = 1'b0;
    repeat (20) step();
    btns_raw[3] = 1'b1;
    repeat (29) step();
    check("t4_level_gone", 32'(btns_level[3]), 32'h0);
    check("t4_frame_latched", 32'(btns_frame[3]), 32'h1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("t4_frame_cleared", 32'(btns_frame[3]), 32'h0);
    repeat (3) step();

    // 4b. Press pulse coincident with frame_tick: set wins
    btns_raw[3] = 1'b0;
    repeat (7) step();
    check("t4b_press_now", 32'(btns_press[3]), 32'h1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    btns_raw[3] = 1'b1;
    repeat (8) step();
    check("t4b_level_gone", 32'(btns_level[3]), 32'h0);
    check("t4b_latch_kept", 32'(btns_frame[3]), 32'h1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("t4b_latch_cleared", 32'(btns_frame[3]), 32'h0);
    repeat (3) step();
`else
    // Without the latch the frame output follows the level
    btns_raw[3] = 1'b0;
    repeat (7) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("t4_frame_is_level", 32'(btns_frame), 32'(btns_level));
    btns_raw[3] = 1'b1;
    repeat (8) step();
    check("t4_frame_released", 32'(btns_frame[3]), 32'h0);
`endif

    // 5. Reset mid-count with bit 0 already pressed
    btns_raw = 4'hE;
    repeat (8) step();
    check("t5_bit0_pressed", 32'(btns_level), 32'h1);
    btns_raw = 4'h6;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t5_async_level", 32'(btns_level), 32'h0);
    check("t5_async_frame", 32'(btns_frame), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("t5_level_before_edge6", 32'(btns_level), 32'h0);
    step();
    check("t5_level_edge6", 32'(btns_level), 32'h9);
    check("t5_press_edge6", 32'(btns_press), 32'h9);
    btns_raw = 4'hF;
    repeat (10) step();

    // 6. Simultaneous presses
    btns_raw = 4'h0;
    repeat (6) step();
    check("t6_level_before", 32'(btns_level), 32'h0);
    step();
    check("t6_press_all", 32'(btns_press), 32'hF);
    check("t6_level_all", 32'(btns_level), 32'hF);
    step();
    check("t6_press_single", 32'(btns_press), 32'h0);
    btns_raw = 4'hF;
    repeat (10) step();

    // Randomized phase, checked by the scoreboard every cycle
    for (int b = 0; b < int'(N); b++) hold[b] = int'($urandom_range(1, 12));
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < int'(N); b++) begin
        hold[b] = hold[b] - 1;
        if (hold[b] <= 0) begin
          btns_raw[b] = ~btns_raw[b];
          hold[b] = int'($urandom_range(1, 12));
        end
      end
      frame_tick = ($urandom_range(0, 7) == 0);
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      step();
    end
    btns_raw   = 4'hF;
    frame_tick = 1'b0;
    repeat (12) step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
